if_stage: RTL
=============

# if_stage

Instruction-fetch stage of the five-stage pipelined MIPS CPU: owns the PC register, drives the instruction-memory address, and produces the IF/ID pipeline register consumed by decode. It applies start gating, load-use stalls from hazard detection, and branch/jump redirects with IF/ID flush. It optionally counts stall and flush cycles for bench reporting.

## Interface
- RESET_PC, 32'h0000_0000: PC value after reset.
- IMEM_WORDS, 256: instruction-memory depth in 32-bit words; fetches at or beyond IMEM_WORDS*4 return a nop.
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- start_i  in  1  run enable; low freezes PC and injects nops.
- stall_i  in  1  load-use stall from hazard detection.
- branch_taken_i  in  1  branch resolved taken in ID.
- branch_target_i  in  32  branch target address.
- jump_i  in  1  jump decoded in ID.
- jump_target_i  in  32  jump target address.
- imem_instr_i  in  32  instruction word at imem_addr_o, combinational, same cycle.
- imem_addr_o  out  32  equals pc_o.
- pc_o  out  32  current PC.
- ifid_pc4_o  out  32  PC+4 of the instruction held in IF/ID.
- ifid_instr_o  out  32  instruction held in IF/ID (0 = nop).
- ifid_valid_o  out  1  IF/ID holds a real fetched instruction.
- flush_o  out  1  combinational; IF/ID is squashed at the next edge.
- stall_cnt_o  out  32  stall-cycle count.
- flush_cnt_o  out  32  flush-cycle count.

## Operation
- Reset: pc_o=RESET_PC; ifid_pc4_o=0, ifid_instr_o=0, ifid_valid_o=0; counters 0. Reset overrides every other input.
- Per-edge priority: reset > !start_i > stall_i > redirect > sequential.
- !start_i: PC holds. IF/ID loads nop (instr 0, pc4 0, valid 0). Counters hold.
- stall_i (start high): PC and IF/ID hold. Any redirect in the same cycle is ignored; decode re-presents it after the stall. flush_o=0.
- Redirect (start high, no stall): redirect = jump_i | branch_taken_i. jump_i wins when both are set. PC loads the target with bits [1:0] forced to 0. IF/ID loads nop. flush_o=1.
- Sequential: PC loads PC+4 (mod 2^32, wraps). IF/ID loads the fetched word, pc4=PC+4, valid=1.
- Fetched word: imem_instr_i if PC < IMEM_WORDS*4, else 32'h0 with valid still 1.
- Counters, non-saturating, wrap at 2^32:
  - stall_cnt increments when start_i & stall_i & !jump_i & !branch_taken_i.
  - flush_cnt increments on each edge where flush_o=1.

## Timing
- Fetch latency 1 cycle: the word addressed at edge N is in IF/ID after edge N+1.
- Redirect penalty is exactly one bubble. The target instruction reaches IF/ID two edges after the redirect cycle.
- flush_o and imem_addr_o are combinational from the current inputs and state; no other output is combinational.
- Reset mid-stall or mid-redirect: the next edge yields the reset values only.
- start_i deasserted mid-stream, then reasserted: fetch resumes from the held PC with no skipped instruction.

## Configuration
- IF_PERF_CNT_EN defined: stall and flush counters are implemented as specified.
- IF_PERF_CNT_EN undefined: no counter flops. stall_cnt_o and flush_cnt_o are tied to 0. All other behaviour is identical.

## Test plan
- Reset then start, imem words 0..3 = A,B,C,D, no hazards: pc_o 0,4,8,12 on successive edges. IF/ID shows A (pc4=4) after the second edge, then B, C.
- stall_i high for 2 cycles while PC=8: pc_o stays 8 and IF/ID stays B for 2 edges. Then resumes with C. stall_cnt_o=2 (with IF_PERF_CNT_EN).
- branch_taken_i with target 0x40 at PC=12: flush_o=1, next pc_o=0x40, IF/ID=nop, flush_cnt_o=1. The next edge loads mem[16] into IF/ID.
- Conflicting controls, one at a time:
  - jump_i (target 0x20) and branch_taken_i (target 0x40) together: pc_o=0x20.
  - stall_i together with jump_i: PC holds, flush_o=0, counters unchanged.
- Boundary cases:
  - PC=1020 with IMEM_WORDS=256: IF/ID gets pc4=1024. At PC=1024 the fetched word is 0.
  - Jump target 0x23: pc_o=0x20.
- rst_i high during a redirect cycle: pc_o=0, IF/ID zeroed, counters 0. start_i low for 3 cycles: pc_o frozen, ifid_valid_o=0.

Source files
------------

// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
// Module      : if_stage
// Description : Instruction-fetch stage. Owns the PC, drives the imem address
//               and holds the IF/ID register. Handles start gating, load-use
//               stalls and branch/jump redirects with IF/ID flush.
//               Optional stall/flush counters when IF_PERF_CNT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module if_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_WORDS = 256
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        stall_i,
    input  logic        branch_taken_i,
    input  logic [31:0] branch_target_i,
    input  logic        jump_i,
    input  logic [31:0] jump_target_i,
    input  logic [31:0] imem_instr_i,
    output logic [31:0] imem_addr_o,
    output logic [31:0] pc_o,
    output logic [31:0] ifid_pc4_o,
    output logic [31:0] ifid_instr_o,
    output logic        ifid_valid_o,
    output logic        flush_o,
    output logic [31:0] stall_cnt_o,
    output logic [31:0] flush_cnt_o
);

    // 33 bits so the compare stays correct even if the memory spans 4 GiB
    localparam logic [32:0] c_IMEM_BYTES = 33'(IMEM_WORDS) * 33'd4;

    logic [31:0] r_pc;
    logic [31:0] r_ifid_pc4;
    logic [31:0] r_ifid_instr;
    logic        r_ifid_valid;

    logic        w_redirect;
    logic        w_flush;
    logic [31:0] w_target_raw;
    logic [31:0] w_target;
    logic [31:0] w_pc_plus4;
    logic        w_in_range;
    logic [31:0] w_fetch_word;

    assign w_redirect   = jump_i | branch_taken_i;
    assign w_flush      = start_i & ~stall_i & w_redirect;
    assign w_target_raw = jump_i ? jump_target_i : branch_target_i;
    assign w_target     = w_target_raw & ~32'd3;
    assign w_pc_plus4   = r_pc + 32'd4;
    assign w_in_range   = ({1'b0, r_pc} < c_IMEM_BYTES);
    assign w_fetch_word = w_in_range ? imem_instr_i : 32'h0000_0000;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_pc         <= RESET_PC;
            r_ifid_pc4   <= 32'h0;
            r_ifid_instr <= 32'h0;
            r_ifid_valid <= 1'b0;
        end else if (!start_i) begin
            r_ifid_pc4   <= 32'h0;
            r_ifid_instr <= 32'h0;
            r_ifid_valid <= 1'b0;
        end else if (!stall_i) begin
            if (w_redirect) begin
                r_pc         <= w_target;
                r_ifid_pc4   <= 32'h0;
                r_ifid_instr <= 32'h0;
                r_ifid_valid <= 1'b0;
            end else begin
                r_pc         <= w_pc_plus4;
                r_ifid_pc4   <= w_pc_plus4;
                r_ifid_instr <= w_fetch_word;
                r_ifid_valid <= 1'b1;
            end
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    // A stall that coincides with a redirect is not counted as a stall cycle
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_stall_cnt <= 32'h0;
            r_flush_cnt <= 32'h0;
        end else begin
            if (start_i && stall_i && !jump_i && !branch_taken_i) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (w_flush) begin
                r_flush_cnt <= r_flush_cnt + 32'd1;
            end
        end
    end

    assign stall_cnt_o = r_stall_cnt;
    assign flush_cnt_o = r_flush_cnt;
`else
    assign stall_cnt_o = 32'h0;
    assign flush_cnt_o = 32'h0;
`endif

    assign imem_addr_o  = r_pc;
    assign pc_o         = r_pc;
    assign ifid_pc4_o   = r_ifid_pc4;
    assign ifid_instr_o = r_ifid_instr;
    assign ifid_valid_o = r_ifid_valid;
    assign flush_o      = w_flush;

endmodule
`default_nettype wire
